// File: rtl/out_counter_mc.sv
// Multi-channel event counter with a per-channel programmable lock window.
// Latency: an accepted ena updates out_cnt/busy/accept at the next rising edge.
// No backpressure: ena is level-sampled and dropped while a channel is locked.
// Optional feature macro OUT_CNT_VETO_CNT_EN adds veto_cnt, a per-channel count of
// ena rising edges that arrive during a lock window.
module out_counter_mc #(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 16,
    parameter int LOCK_W   = 15,
    parameter int SATURATE = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic [N_CH-1:0]         ena,
    input  logic [LOCK_W-1:0]       lock_time,
    output logic [N_CH*CNT_W-1:0]   out_cnt,
    output logic [N_CH-1:0]         busy,
    output logic [N_CH-1:0]         accept,
    output logic [N_CH-1:0]         ovf
`ifdef OUT_CNT_VETO_CNT_EN
    ,
    output logic [N_CH*CNT_W-1:0]   veto_cnt
`endif
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_LOCK = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic              state_q;
        logic [CNT_W-1:0]  cnt_q;
        logic [LOCK_W-1:0] lt_q;
        logic [LOCK_W-1:0] lock_cnt_q;
        logic              accept_q;
        logic              ovf_q;

        // Per-channel IDLE/LOCK machine: count on accept, then hold off for lt_q+1 cycles.
        // lt_q is captured at accept so a lock_time change never stretches a running window.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q    <= ST_IDLE;
                cnt_q      <= '0;
                lt_q       <= '0;
                lock_cnt_q <= '0;
                accept_q   <= 1'b0;
                ovf_q      <= 1'b0;
            end else if (clr) begin
                state_q    <= ST_IDLE;
                cnt_q      <= '0;
                lock_cnt_q <= '0;
                accept_q   <= 1'b0;
                ovf_q      <= 1'b0;
            end else if (state_q == ST_IDLE) begin
                accept_q <= ena[i];
                if (ena[i]) begin
                    if (cnt_q == CNT_MAX) begin
                        ovf_q <= 1'b1;
                        cnt_q <= (SATURATE != 0) ? CNT_MAX : '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    lt_q       <= lock_time;
                    lock_cnt_q <= '0;
                    state_q    <= ST_LOCK;
                end
            end else begin
                accept_q <= 1'b0;
                // Compare before increment: with lt_q all-ones the counter stops at
                // all-ones and never wraps.
                if (lock_cnt_q == lt_q) begin
                    lock_cnt_q <= '0;
                    state_q    <= ST_IDLE;
                end else begin
                    lock_cnt_q <= lock_cnt_q + LOCK_W'(1);
                end
            end
        end

        assign out_cnt[i*CNT_W +: CNT_W] = cnt_q;
        assign busy[i]                   = (state_q == ST_LOCK);
        assign accept[i]                 = accept_q;
        assign ovf[i]                    = ovf_q;

`ifdef OUT_CNT_VETO_CNT_EN
        logic             ena_q;
        logic [CNT_W-1:0] veto_q;

        // Count ena rising edges seen while locked; saturates regardless of SATURATE.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                ena_q  <= 1'b0;
                veto_q <= '0;
            end else begin
                ena_q <= ena[i];
                if (clr) begin
                    veto_q <= '0;
                end else if ((state_q == ST_LOCK) && ena[i] && !ena_q && (veto_q != CNT_MAX)) begin
                    veto_q <= veto_q + CNT_W'(1);
                end
            end
        end

        assign veto_cnt[i*CNT_W +: CNT_W] = veto_q;
`endif
    end

endmodule

// File: tb/tb_out_counter_mc.sv
// Bench for out_counter_mc: two instances (wrap and saturate) share stimulus.
// A remaining-cycles reference model is compared on every cycle, plus directed checks.
// Counters are 8 bits wide here so overflow is reachable within a short run.
module tb_out_counter_mc;

    localparam int NC = 4;
    localparam int CW = 8;
    localparam int LW = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              clr;
    logic [NC-1:0]     ena;
    logic [LW-1:0]     lock_time;
    logic [NC*CW-1:0]  out_cnt0, out_cnt1;
    logic [NC-1:0]     busy0, busy1, accept0, accept1, ovf0, ovf1;
`ifdef OUT_CNT_VETO_CNT_EN
    logic [NC*CW-1:0]  veto0, veto1;
`endif

    always #5 clk = ~clk;

    out_counter_mc #(.N_CH(NC), .CNT_W(CW), .LOCK_W(LW), .SATURATE(0)) dut0 (
        .clk(clk), .reset(reset), .clr(clr), .ena(ena), .lock_time(lock_time),
        .out_cnt(out_cnt0), .busy(busy0), .accept(accept0), .ovf(ovf0)
`ifdef OUT_CNT_VETO_CNT_EN
        , .veto_cnt(veto0)
`endif
    );

    out_counter_mc #(.N_CH(NC), .CNT_W(CW), .LOCK_W(LW), .SATURATE(1)) dut1 (
        .clk(clk), .reset(reset), .clr(clr), .ena(ena), .lock_time(lock_time),
        .out_cnt(out_cnt1), .busy(busy1), .accept(accept1), .ovf(ovf1)
`ifdef OUT_CNT_VETO_CNT_EN
        , .veto_cnt(veto1)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [CW-1:0] m_cnt0 [NC];
    logic [CW-1:0] m_cnt1 [NC];
    logic [CW-1:0] m_veto [NC];
    int            m_left [NC];   // cycles of lock still to run (0 = idle)
    bit            m_acc  [NC];
    bit            m_ovf  [NC];
    bit            m_prev [NC];

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_cnt0[c] = '0; m_cnt1[c] = '0; m_veto[c] = '0;
            m_left[c] = 0;  m_acc[c]  = 0;  m_ovf[c]  = 0; m_prev[c] = 0;
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < NC; c++) begin
            if (clr) begin
                m_cnt0[c] = '0; m_cnt1[c] = '0; m_veto[c] = '0;
                m_left[c] = 0;  m_acc[c]  = 0;  m_ovf[c]  = 0;
            end else if (m_left[c] == 0 && ena[c]) begin
                m_acc[c] = 1;
                if (m_cnt0[c] == {CW{1'b1}} || m_cnt1[c] == {CW{1'b1}}) m_ovf[c] = 1;
                m_cnt0[c] = m_cnt0[c] + 1'b1;
                if (m_cnt1[c] != {CW{1'b1}}) m_cnt1[c] = m_cnt1[c] + 1'b1;
                m_left[c] = int'(lock_time) + 1;
            end else begin
                m_acc[c] = 0;
                if (m_left[c] > 0) begin
                    if (ena[c] && !m_prev[c] && m_veto[c] != {CW{1'b1}}) m_veto[c] = m_veto[c] + 1'b1;
                    m_left[c] = m_left[c] - 1;
                end
            end
            m_prev[c] = ena[c];
        end
    endtask

    function automatic logic [NC*CW-1:0] pack_w(input logic [CW-1:0] a [NC]);
        logic [NC*CW-1:0] v;
        for (int c = 0; c < NC; c++) v[c*CW +: CW] = a[c];
        return v;
    endfunction

    function automatic logic [NC-1:0] pack_b(input bit a [NC]);
        logic [NC-1:0] v;
        for (int c = 0; c < NC; c++) v[c] = a[c];
        return v;
    endfunction

    function automatic logic [NC-1:0] model_busy();
        logic [NC-1:0] v;
        for (int c = 0; c < NC; c++) v[c] = (m_left[c] > 0);
        return v;
    endfunction

    task automatic model_check();
        chk("model_cnt_wrap", out_cnt0, pack_w(m_cnt0));
        chk("model_cnt_sat",  out_cnt1, pack_w(m_cnt1));
        chk("model_busy_wrap", busy0, model_busy());
        chk("model_busy_sat",  busy1, model_busy());
        chk("model_acc_wrap", accept0, pack_b(m_acc));
        chk("model_acc_sat",  accept1, pack_b(m_acc));
        chk("model_ovf_wrap", ovf0, pack_b(m_ovf));
        chk("model_ovf_sat",  ovf1, pack_b(m_ovf));
`ifdef OUT_CNT_VETO_CNT_EN
        chk("model_veto_wrap", veto0, pack_w(m_veto));
        chk("model_veto_sat",  veto1, pack_w(m_veto));
`endif
    endtask

    // Inputs are changed only at negedge; one call = one rising edge + checks.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        model_check();
    endtask

    task automatic do_clr();
        clr = 1'b1; ena = '0; step(); clr = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic          clr;
        logic [NC-1:0] ena;
        logic          exp_acc0;
        logic          exp_busy0;
        logic [NC*CW-1:0] exp_cnt;
    } vec_t;

    vec_t vt [11];
    int   n, acc_n;

    initial begin
        vt[0]  = '{1'b0, 4'b0001, 1'b1, 1'b1, 32'h1};
        vt[1]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 32'h1};
        vt[2]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 32'h1};
        vt[3]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 32'h1};
        vt[4]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 32'h1};
        vt[5]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 32'h1};
        vt[6]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 32'h1};
        vt[7]  = '{1'b0, 4'b0001, 1'b1, 1'b1, 32'h2};
        vt[8]  = '{1'b1, 4'b0001, 1'b0, 1'b0, 32'h0};
        vt[9]  = '{1'b0, 4'b0001, 1'b1, 1'b1, 32'h1};
        vt[10] = '{1'b0, 4'b0000, 1'b0, 1'b1, 32'h1};

        reset = 1'b0; clr = 1'b0; ena = '0; lock_time = 15'd5;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_cnt",  {out_cnt1, out_cnt0}, 64'h0);
        chk("reset_flags", {busy1, busy0, accept1, accept0, ovf1, ovf0}, 24'h0);
        reset = 1'b1;

        // single pulse, lock_time=5, then clr-vs-ena priority
        for (int i = 0; i < 11; i++) begin
            clr = vt[i].clr; ena = vt[i].ena;
            step();
            chk($sformatf("tbl%0d_acc", i),  accept0, {3'b000, vt[i].exp_acc0});
            chk($sformatf("tbl%0d_busy", i), busy0,   {3'b000, vt[i].exp_busy0});
            chk($sformatf("tbl%0d_cnt", i),  out_cnt0, vt[i].exp_cnt);
        end
        clr = 1'b0; ena = '0;
        do_clr();

        // ena[1] held 40 cycles at lock_time=3 -> accept every 5 cycles
        lock_time = 15'd3; ena = 4'b0010; acc_n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (accept0[1]) acc_n++;
        end
        ena = '0;
        chk("held_accepts", acc_n, 8);
        chk("held_cnt1", out_cnt0[CW +: CW], 8);
        do_clr();

        // lock_time change mid-window only affects the next window
        lock_time = 15'd10; ena = 4'b0001; step();
        ena = '0; lock_time = 15'd2; n = 0;
        while (busy0[0] && n < 100) begin n++; step(); end
        chk("win_current", n, 11);
        ena = 4'b0001; step(); ena = '0; n = 0;
        while (busy0[0] && n < 100) begin n++; step(); end
        chk("win_next", n, 3);

        // all-ones lock_time: window of 2^LOCK_W cycles
        lock_time = 15'h7FFF; ena = 4'b0001; step(); ena = '0; lock_time = 15'd0; n = 0;
        while (busy0[0] && n < 40000) begin n++; step(); end
        chk("win_max", n, 32768);
        do_clr();

        // overflow: 255 accepts then one more
        lock_time = 15'd0; ena = 4'b0001;
        repeat (509) step();
        chk("pre_ovf_cnt", {out_cnt1[7:0], out_cnt0[7:0]}, 16'hFFFF);
        chk("pre_ovf_flag", {ovf1[0], ovf0[0]}, 2'b00);
        repeat (2) step();
        ena = '0;
        chk("ovf_wrap_cnt", out_cnt0[7:0], 8'h00);
        chk("ovf_sat_cnt",  out_cnt1[7:0], 8'hFF);
        chk("ovf_flags",    {ovf1[0], ovf0[0]}, 2'b11);
        repeat (3) step();
        chk("ovf_sticky",   {ovf1[0], ovf0[0]}, 2'b11);
        do_clr();
        chk("ovf_clr", {ovf1, ovf0}, 8'h00);

        // clr wins over ena on channel 2 holding 7
        lock_time = 15'd0; ena = 4'b0100;
        repeat (13) step();
        ena = '0; step();
        chk("ch2_pre", out_cnt0[2*CW +: CW], 7);
        clr = 1'b1; ena = 4'b0100; step();
        chk("clr_cnt2",  out_cnt0[2*CW +: CW], 0);
        chk("clr_busy2", busy0[2], 1'b0);
        chk("clr_acc2",  accept0[2], 1'b0);
        clr = 1'b0; ena = '0;
        step();

        // asynchronous reset in the middle of a window
        lock_time = 15'd20; ena = 4'b0001; step(); ena = '0;
        repeat (3) step();
        chk("midlock_busy", busy0[0], 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("arst_cnt",   {out_cnt1, out_cnt0}, 64'h0);
        chk("arst_flags", {busy1, busy0, accept1, accept0, ovf1, ovf0}, 24'h0);
        model_reset();
        #1 reset = 1'b1;
        @(negedge clk);
        step();
        chk("post_arst_idle", busy0[0], 1'b0);

`ifdef OUT_CNT_VETO_CNT_EN
        // three separate pulses inside one window
        do_clr();
        lock_time = 15'd20;
        ena = 4'b1000; step(); ena = '0; step(); step();
        ena = 4'b1000; step(); ena = '0; step();
        ena = 4'b1000; step(); ena = '0; step();
        chk("veto_cnt3", out_cnt0[3*CW +: CW], 1);
        chk("veto_veto3", veto0[3*CW +: CW], 2);
        chk("veto_sat3",  veto1[3*CW +: CW], 2);
`endif

        // randomized traffic against the model
        do_clr();
        for (int i = 0; i < 4000; i++) begin
            ena       = NC'($urandom);
            if ($urandom_range(0, 3) == 0) lock_time = LW'($urandom_range(0, 6));
            clr       = ($urandom_range(0, 999) == 0);
            step();
        end
        clr = 1'b0; ena = '0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/out_counter_mc.md
# out_counter_mc

Multi-channel successor to the single-channel event output counter. Each of `N_CH` channels counts accepted `ena` events. After each accepted event the channel ignores further `ena` for a runtime-programmable lock window. Sits after the ADC header decoders, one channel per ADC stream, and feeds the event-count readout and status registers.

## Interface
- `N_CH`, 4, number of independent channels (1..16)
- `CNT_W`, 16, width of each event counter
- `LOCK_W`, 15, width of lock-time register and per-channel lock counter
- `SATURATE`, 0, 0: event counter wraps to 0; 1: event counter holds at all-ones

- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset)
- `clr`  in  1  synchronous clear of all channels, active-high
- `ena`  in  N_CH  per-channel event strobe (level-sampled), bit i = channel i
- `lock_time`  in  LOCK_W  lock window length, shared by all channels
- `out_cnt`  out  N_CH*CNT_W  event counters, channel i at bits [i*CNT_W +: CNT_W]
- `busy`  out  N_CH  channel i is locked
- `accept`  out  N_CH  one-cycle pulse on the cycle an event is accepted (registered)
- `ovf`  out  N_CH  sticky: counter reached/passed all-ones

## Operation
- Per-channel states: IDLE (`busy`=0) and LOCK (`busy`=1).
- IDLE, `ena[i]`=1:
  - `out_cnt[i]`+1;
  - `accept[i]`=1 for one cycle;
  - `lock_time` latched into per-channel `lt_q[i]`;
  - `lock_cnt[i]`←0;
  - go to LOCK.
- LOCK:
  - `ena[i]` ignored.
  - `lock_cnt[i]`+1 each cycle.
  - When `lock_cnt[i]==lt_q[i]`: `lock_cnt[i]`←0, go to IDLE.
- `lock_time` changes affect only the next accepted event, never an active window.
- Overflow:
  - Increment from all-ones with `SATURATE`=0: counter wraps to 0 and `ovf[i]` sets.
  - Increment from all-ones with `SATURATE`=1: counter stays all-ones and `ovf[i]` sets.
  - `ovf` clears only by `reset` or `clr`.
- `clr`=1 has priority over any `ena` that cycle. It forces, for all channels:
  - `out_cnt`=0, `busy`=0, `accept`=0, `ovf`=0, `lock_cnt`=0.
- Channels are fully independent. Simultaneous `ena` on several channels are all accepted.
- Reset values (`reset`=0, immediate): `out_cnt`=0, `busy`=0, `accept`=0, `ovf`=0, internal counters 0, `veto_cnt`=0.
- Reset mid-lock aborts the window; the channel is IDLE on the first edge after release.

## Timing
- Cycle N: `ena[i]` sampled high in IDLE.
- Edge N+1: `out_cnt[i]` updated, `busy[i]`=1, `accept[i]`=1.
- Edge N+2: `accept[i]`=0.
- `busy[i]` stays high for exactly `lt_q[i]`+1 cycles.
- `ena[i]` is accepted again on the first cycle `busy[i]` reads 0, so the minimum spacing of accepts is `lt_q`+2 cycles.
- `lock_time`=0: `busy` is high for 1 cycle; `ena` held high continuously gives an accept every 2 cycles.
- `lock_time`=all-ones: window is 2^LOCK_W cycles. `lock_cnt` never wraps before its compare.
- `ena` held high across the whole window produces exactly one accept per window.
- `clr` takes effect at the next edge.

## Configuration
- `OUT_CNT_VETO_CNT_EN` defined:
  - Adds output `veto_cnt` (out, N_CH*CNT_W), channel i at bits [i*CNT_W +: CNT_W].
  - Counts rising edges of `ena[i]` (registered `ena` was 0, current is 1) that arrive while `busy[i]`=1.
  - Always saturates at all-ones, regardless of `SATURATE`.
  - Cleared by `reset` and `clr`.
  - The `ena` history register resets to 0.
- Not defined: port and logic are absent; all other behaviour is identical.

## Test plan
- Reset release, `lock_time`=5, single 1-cycle `ena[0]` pulse:
  - `accept[0]` pulses once;
  - `out_cnt[0]`=1;
  - `busy[0]` high exactly 6 cycles;
  - other channels remain 0.
- `ena[1]` held high 40 cycles, `lock_time`=3 → accepts every 5 cycles, `out_cnt[1]`=8.
- `lock_time`=10 at accept, changed to 2 mid-window → current window still 11 cycles; next window 3 cycles.
- `out_cnt` preloaded to 0xFFFF via 65535 accepts at `lock_time`=0, then one more accept:
  - `SATURATE`=0 → counter 0x0000, `ovf`=1;
  - `SATURATE`=1 → counter 0xFFFF, `ovf`=1.
- `clr` and `ena[2]` asserted in the same cycle while `out_cnt[2]`=7 → `out_cnt[2]`=0, `busy[2]`=0, no `accept`. Asynchronous `reset` asserted mid-lock → all outputs 0 immediately.
- With `OUT_CNT_VETO_CNT_EN`, `lock_time`=20, three separate `ena[3]` pulses inside one window → `out_cnt[3]`=1, `veto_cnt[3]`=2.
